// File: rtl/mips_cpu_pkg.sv
// Shared types and instruction-field constants for the multicycle MIPS CPU.
// The sequencer and the controller import the same state encoding from here.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC1  = 3'd3,
    EXEC2  = 3'd4
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;

  localparam logic [4:0] RI_BLTZAL = 5'h10;
  localparam logic [4:0] RI_BGEZAL = 5'h11;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier: which instructions touch memory,
// which read HI/LO, and which need a second execute cycle.
module mips_cpu_instr_class
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] fncode,
  input  logic [4:0] regimm,
  output logic       is_mem,
  output logic       need2,
  output logic       is_mf
);

  logic is_load;
  logic is_link_branch;

  assign is_load        = opcode inside {[OP_LB:OP_LWR]};
  assign is_mem         = is_load || (opcode inside {OP_SB, OP_SH, OP_SW});
  assign is_mf          = (opcode == OP_SPECIAL) && (fncode inside {FN_MFHI, FN_MFLO});
  // Link branches spend the extra cycle writing the return address to r31.
  assign is_link_branch = (opcode == OP_REGIMM) && (regimm inside {RI_BLTZAL, RI_BGEZAL});
  assign need2          = is_load || is_link_branch;

endmodule

// File: rtl/mips_cpu_state_sequencer.sv
// Multicycle sequencer: FETCH -> DECODE -> EXEC1 [-> EXEC2], with memory and
// mul/div stalls, halt detection on next PC, and cycle/retire counters.
module mips_cpu_state_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fncode,
  input  logic [4:0]       regimm,
  input  logic [31:0]      pc_next,
  input  logic             muldiv_busy,
  output logic [2:0]       state,
  output logic             active,
  output logic             instr_retired,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  state_t state_q;
  state_t state_d;
  logic   is_mem;
  logic   need2;
  logic   is_mf;
  logic   hold;

  mips_cpu_instr_class u_class (
    .opcode (opcode),
    .fncode (fncode),
    .regimm (regimm),
    .is_mem (is_mem),
    .need2  (need2),
    .is_mf  (is_mf)
  );

  // A stall needs a matching cause: waitrequest only matters for memory ops,
  // muldiv_busy only for reads of HI/LO.
  assign hold = (is_mem && waitrequest) || (is_mf && muldiv_busy);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    instr_retired = 1'b0;
    unique case (state_q)
      HALTED: state_d = HALTED;
      FETCH:  if (!waitrequest) state_d = DECODE;
      DECODE: state_d = EXEC1;
      EXEC1: begin
        if (!hold) begin
          if (need2) state_d = EXEC2;
          else       instr_retired = 1'b1;
        end
      end
      EXEC2:   instr_retired = 1'b1;
      default: state_d = HALTED;
    endcase
    if (instr_retired) state_d = (pc_next == HALT_ADDR) ? HALTED : FETCH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != HALTED) cycle_count <= cycle_count + CNT_W'(1);
      if (instr_retired)     retired_count <= retired_count + CNT_W'(1);
    end
  end

  assign state  = state_q;
  assign active = (state_q != HALTED);

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Table-driven bench for the multicycle sequencer: per-cycle vectors feed a
// scoreboard queue checked on the falling edge, plus reset/halt sequences.
module tb_mips_cpu_state_sequencer;

  typedef struct {
    logic        wr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  ri;
    logic [31:0] pcn;
    logic        mdb;
    logic [2:0]  st;
    logic        ret;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       ret;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  fncode = '0;
  logic [4:0]  regimm = '0;
  logic [31:0] pc_next = 32'h4;
  logic        muldiv_busy = 1'b0;
  logic [2:0]  state;
  logic        active;
  logic        instr_retired;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];
  exp_t sb[$];

  mips_cpu_state_sequencer #(.HALT_ADDR(32'h0), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .waitrequest   (waitrequest),
    .opcode        (opcode),
    .fncode        (fncode),
    .regimm        (regimm),
    .pc_next       (pc_next),
    .muldiv_busy   (muldiv_busy),
    .state         (state),
    .active        (active),
    .instr_retired (instr_retired),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compares each cycle's outputs mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, " state"}, 32'(state), 32'(e.st));
      check({e.tag, " retired"}, 32'(instr_retired), 32'(e.ret));
      check({e.tag, " active"}, 32'(active), 32'(e.st != 3'd0));
    end
  end

  task automatic add(input logic wr, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] ri, input logic [31:0] pcn, input logic mdb,
                     input logic [2:0] st, input logic ret);
    vec_t v;
    v.wr = wr; v.op = op; v.fn = fn; v.ri = ri; v.pcn = pcn; v.mdb = mdb;
    v.st = st; v.ret = ret;
    tbl.push_back(v);
  endtask

  // Called just after a rising edge; leaves the bench just after the next one.
  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      waitrequest = tbl[i].wr;
      opcode      = tbl[i].op;
      fncode      = tbl[i].fn;
      regimm      = tbl[i].ri;
      pc_next     = tbl[i].pcn;
      muldiv_busy = tbl[i].mdb;
      e.st  = tbl[i].st;
      e.ret = tbl[i].ret;
      e.tag = $sformatf("%s[%0d]", name, i);
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    waitrequest = 1'b0; opcode = '0; fncode = '0; regimm = '0;
    pc_next = 32'h4; muldiv_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst state", 32'(state), 32'd1);
    check("rst active", 32'(active), 32'd1);
    check("rst retired", 32'(instr_retired), 32'd0);
    check("rst cycles", cycle_count, 32'd0);
    check("rst retcnt", retired_count, 32'd0);
    reset = 1'b0;
  endtask

  task automatic check_end(input string name, input logic [2:0] st,
                           input logic [31:0] cyc, input logic [31:0] ret);
    check({name, " end state"}, 32'(state), 32'(st));
    check({name, " cycles"}, cycle_count, cyc);
    check({name, " retcnt"}, retired_count, ret);
  endtask

  initial begin
    // ADDIU, no stalls.
    do_reset();
    add(0, 6'h09, 0, 0, 32'h4, 0, 3'd1, 0);
    add(0, 6'h09, 0, 0, 32'h4, 0, 3'd2, 0);
    add(0, 6'h09, 0, 0, 32'h4, 0, 3'd3, 1);
    run_tbl("addiu");
    check_end("addiu", 3'd1, 32'd3, 32'd1);

    // LW: 2 fetch waits, 3 EXEC1 waits, then EXEC2.
    do_reset();
    add(1, 6'h23, 0, 0, 32'h8, 0, 3'd1, 0);
    add(1, 6'h23, 0, 0, 32'h8, 0, 3'd1, 0);
    add(0, 6'h23, 0, 0, 32'h8, 0, 3'd1, 0);
    add(0, 6'h23, 0, 0, 32'h8, 0, 3'd2, 0);
    add(1, 6'h23, 0, 0, 32'h8, 0, 3'd3, 0);
    add(1, 6'h23, 0, 0, 32'h8, 0, 3'd3, 0);
    add(1, 6'h23, 0, 0, 32'h8, 0, 3'd3, 0);
    add(0, 6'h23, 0, 0, 32'h8, 0, 3'd3, 0);
    add(0, 6'h23, 0, 0, 32'h8, 0, 3'd4, 1);
    run_tbl("lw");
    check_end("lw", 3'd1, 32'd9, 32'd1);

    // BGEZAL with waitrequest and muldiv_busy high in execute: no stall.
    do_reset();
    add(0, 6'h01, 0, 5'h11, 32'h10, 0, 3'd1, 0);
    add(0, 6'h01, 0, 5'h11, 32'h10, 0, 3'd2, 0);
    add(1, 6'h01, 0, 5'h11, 32'h10, 1, 3'd3, 0);
    add(1, 6'h01, 0, 5'h11, 32'h10, 1, 3'd4, 1);
    // BLTZ (regimm 0) is single-cycle execute; SB without wait has no EXEC2.
    add(0, 6'h01, 0, 5'h00, 32'h14, 0, 3'd1, 0);
    add(0, 6'h01, 0, 5'h00, 32'h14, 0, 3'd2, 0);
    add(0, 6'h01, 0, 5'h00, 32'h14, 0, 3'd3, 1);
    add(0, 6'h28, 0, 0, 32'h18, 0, 3'd1, 0);
    add(0, 6'h28, 0, 0, 32'h18, 0, 3'd2, 0);
    add(0, 6'h28, 0, 0, 32'h18, 0, 3'd3, 1);
    // Unknown opcode with both stall inputs high: one EXEC1, retires.
    add(0, 6'h3F, 6'h12, 0, 32'h1C, 1, 3'd1, 0);
    add(0, 6'h3F, 6'h12, 0, 32'h1C, 1, 3'd2, 0);
    add(1, 6'h3F, 6'h12, 0, 32'h1C, 1, 3'd3, 1);
    run_tbl("branch");
    check_end("branch", 3'd1, 32'd13, 32'd4);

    // MFLO held by muldiv_busy for 5 cycles.
    do_reset();
    add(0, 6'h00, 6'h12, 0, 32'h20, 0, 3'd1, 0);
    add(0, 6'h00, 6'h12, 0, 32'h20, 0, 3'd2, 0);
    for (int i = 0; i < 5; i++) add(1, 6'h00, 6'h12, 0, 32'h20, 1, 3'd3, 0);
    add(0, 6'h00, 6'h12, 0, 32'h20, 0, 3'd3, 1);
    run_tbl("mflo");
    check_end("mflo", 3'd1, 32'd8, 32'd1);

    // JR 0 then delay-slot ADDIU; halt only after the delay slot retires.
    do_reset();
    add(0, 6'h00, 6'h08, 0, 32'h104, 0, 3'd1, 0);
    add(0, 6'h00, 6'h08, 0, 32'h104, 0, 3'd2, 0);
    add(0, 6'h00, 6'h08, 0, 32'h104, 0, 3'd3, 1);
    add(0, 6'h09, 0, 0, 32'h0, 0, 3'd1, 0);
    add(0, 6'h09, 0, 0, 32'h0, 0, 3'd2, 0);
    add(0, 6'h09, 0, 0, 32'h0, 0, 3'd3, 1);
    run_tbl("jr");
    check_end("jr", 3'd0, 32'd6, 32'd2);
    for (int i = 0; i < 20; i++) begin
      add(1'($urandom), 6'($urandom), 6'($urandom), 5'($urandom), 32'($urandom),
          1'($urandom), 3'd0, 0);
    end
    run_tbl("halted");
    check_end("halted", 3'd0, 32'd6, 32'd2);

    // Async reset mid-EXEC1 of a stalled SW.
    do_reset();
    add(0, 6'h2B, 0, 0, 32'h30, 0, 3'd1, 0);
    add(0, 6'h2B, 0, 0, 32'h30, 0, 3'd2, 0);
    add(1, 6'h2B, 0, 0, 32'h30, 0, 3'd3, 0);
    run_tbl("sw");
    check("sw pre state", 32'(state), 32'd3);
    check("sw pre cycles", cycle_count, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("sw rst state", 32'(state), 32'd1);
    check("sw rst retired", 32'(instr_retired), 32'd0);
    check("sw rst cycles", cycle_count, 32'd0);
    check("sw rst retcnt", retired_count, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("sw held retcnt", retired_count, 32'd0);
    reset = 1'b0;

    check("sb drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
